// File: rtl/data_memory_io_if.sv
// Processor memory port plus the TX stream drained by a valid/ready consumer.
// slave: the data-memory block; master: processor and consumer side.
interface data_memory_io_if;
  logic [31:0] m_address;
  logic [31:0] m_data;
  logic        memw_m;
  logic [31:0] data;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  modport slave (
    input  m_address,
    input  m_data,
    input  memw_m,
    output data,
    input  tx_ready,
    output tx_valid,
    output tx_data
  );

  modport master (
    output m_address,
    output m_data,
    output memw_m,
    input  data,
    output tx_ready,
    input  tx_valid,
    input  tx_data
  );
endinterface

// File: rtl/data_memory_io.sv
// Data-memory stage: aliased word RAM plus an I/O window (TX FIFO, STATUS, CYCLES).
// Optional cycle counter enabled by defining DMEM_CYCLE_COUNTER_EN.
module data_memory_io #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] IO_BASE     = 32'h0000_1000
) (
  input logic              clk,
  input logic              rst,
  data_memory_io_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [29:0] IO_W = IO_BASE[31:2];

  // ---------------------------------------------------------------- decode
  logic [29:0]   word_a;
  logic [AW-1:0] ram_idx;
  logic          in_ram;
  logic          hit_tx;
  logic          hit_st;
  logic          hit_cy;

  always_comb begin
    word_a  = bus.m_address[31:2];
    ram_idx = bus.m_address[AW+1:2];
    in_ram  = (bus.m_address < IO_BASE);
    hit_tx  = !in_ram && (word_a == IO_W);
    hit_st  = !in_ram && (word_a == IO_W + 30'd1);
    hit_cy  = !in_ram && (word_a == IO_W + 30'd2);
  end

  // ------------------------------------------------------------------ RAM
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (bus.memw_m && in_ram) begin
      mem_q[ram_idx] <= bus.m_data;
    end
  end

  // ------------------------------------------------------------ TX FIFO
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    push_req = bus.memw_m && hit_tx;
    pop      = !empty && bus.tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push_req && (!full || pop);

    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (push_ok) begin
      wr_d = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear first so an overflowing push in the same cycle wins.
    if (bus.memw_m && hit_st && bus.m_data[2]) begin
      ovf_d = 1'b0;
    end
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      fifo_q[wr_q] <= bus.m_data;
    end
  end

  always_comb begin
    bus.tx_valid = !empty;
    bus.tx_data  = empty ? '0 : fifo_q[rd_q];
  end

  // ------------------------------------------------------- cycle counter
  logic [31:0] cyc_rd;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

  // ------------------------------------------------------------ read mux
  logic [31:0] count_ext;
  logic [7:0]  count8;
  logic [31:0] status_w;

  always_comb begin
    count_ext = 32'(count_q);
    count8    = (count_ext > 32'd255) ? 8'hFF : count_ext[7:0];
    status_w  = {20'b0, count8, 1'b0, ovf_q, full, empty};

    bus.data = '0;
    if (in_ram) begin
      bus.data = mem_q[ram_idx];
    end else if (hit_st) begin
      bus.data = status_w;
    end else if (hit_cy) begin
      bus.data = cyc_rd;
    end
  end

endmodule

// File: tb/tb_data_memory_io.sv
// Directed self-checking bench for data_memory_io (DEPTH 256, FIFO 8, IO_BASE 0x1000).
module tb_data_memory_io;

  localparam logic [31:0] TXA = 32'h0000_1000;
  localparam logic [31:0] STA = 32'h0000_1004;
  localparam logic [31:0] CYA = 32'h0000_1008;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_memory_io_if bus ();

  data_memory_io #(
    .DEPTH_WORDS (256),
    .FIFO_DEPTH  (8),
    .IO_BASE     (32'h0000_1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus.m_address = a;
    bus.m_data    = d;
    bus.memw_m    = we;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    drive(STA, 32'h0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_tx_valid: got %b exp 0", bus.tx_valid);
    end
    checks++;
    if (bus.tx_data !== 32'h0) begin
      errors++; $display("FAIL reset_tx_data: got %h exp 00000000", bus.tx_data);
    end
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_status: got %h exp 00000001", bus.data);
    end
    drive(CYA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0) begin
      errors++; $display("FAIL reset_cycles: got %h exp 00000000", bus.data);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] exp10, exp11;
`ifdef DMEM_CYCLE_COUNTER_EN
    exp10 = 32'd10;
    exp11 = 32'd11;
`else
    exp10 = 32'd0;
    exp11 = 32'd0;
`endif
    rst = 1'b0;
    drive(CYA, 32'h0, 1'b0);
    repeat (10) tick();
    checks++;
    if (bus.data !== exp10) begin
      errors++; $display("FAIL cycles_10: got %h exp %h", bus.data, exp10);
    end
    drive(CYA, 32'h0000_0123, 1'b1);
    tick();
    drive(CYA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== exp11) begin
      errors++; $display("FAIL cycles_write_ignored: got %h exp %h", bus.data, exp11);
    end
  endtask

  task automatic test_ram();
    drive(32'h10, 32'hDEAD_BEEF, 1'b1);
    tick();
    drive(32'h10, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_read: got %h exp deadbeef", bus.data);
    end
    drive(32'h410, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_alias: got %h exp deadbeef", bus.data);
    end
    drive(32'h10, 32'h1234_5678, 1'b1);
    checks++;
    if (bus.data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_pre_edge: got %h exp deadbeef", bus.data);
    end
    tick();
    drive(32'h813, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h1234_5678) begin
      errors++; $display("FAIL ram_alias_byte: got %h exp 12345678", bus.data);
    end
    drive(32'hFFC, 32'hA5A5_A5A5, 1'b1);
    tick();
    drive(32'h3FC, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL ram_top_word: got %h exp a5a5a5a5", bus.data);
    end
    drive(32'h0C, 32'h0C0C_0C0C, 1'b1);
    tick();
    drive(32'h100C, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (bus.data !== 32'h0) begin
      errors++; $display("FAIL io_unmapped_read: got %h exp 00000000", bus.data);
    end
    tick();
    drive(32'h0C, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0C0C_0C0C) begin
      errors++; $display("FAIL io_unmapped_write: got %h exp 0c0c0c0c", bus.data);
    end
    drive(TXA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0) begin
      errors++; $display("FAIL txdata_read: got %h exp 00000000", bus.data);
    end
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0000_0001) begin
      errors++; $display("FAIL status_still_empty: got %h exp 00000001", bus.data);
    end
  endtask

  task automatic test_fifo_fill();
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(TXA, 32'(i), 1'b1);
      tick();
      if (i == 1) begin
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'd1) begin
          errors++; $display("FAIL push_latency: got v=%b d=%h exp v=1 d=00000001", bus.tx_valid, bus.tx_data);
        end
      end
    end
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0000_0082) begin
      errors++; $display("FAIL status_full: got %h exp 00000082", bus.data);
    end
    drive(TXA, 32'd9, 1'b1);
    tick();
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0000_0086) begin
      errors++; $display("FAIL status_ovf: got %h exp 00000086", bus.data);
    end
    checks++;
    if (bus.tx_data !== 32'd1) begin
      errors++; $display("FAIL head_after_ovf: got %h exp 00000001", bus.tx_data);
    end
  endtask

  task automatic test_push_pop_full();
    bus.tx_ready = 1'b1;
    drive(TXA, 32'd9, 1'b1);
    tick();
    bus.tx_ready = 1'b0;
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.tx_data !== 32'd2) begin
      errors++; $display("FAIL full_pushpop_head: got %h exp 00000002", bus.tx_data);
    end
    checks++;
    if (bus.data !== 32'h0000_0086) begin
      errors++; $display("FAIL full_pushpop_status: got %h exp 00000086", bus.data);
    end
    bus.tx_ready = 1'b1;
    #1;
    for (int e = 2; e <= 9; e++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'(e)) begin
        errors++; $display("FAIL drain_order: got v=%b d=%h exp v=1 d=%h", bus.tx_valid, bus.tx_data, 32'(e));
      end
      tick();
    end
    checks++;
    if (bus.data !== 32'h0000_0005 || bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL drained_status: got %h v=%b exp 00000005 v=0", bus.data, bus.tx_valid);
    end
    tick();
    checks++;
    if (bus.data !== 32'h0000_0005) begin
      errors++; $display("FAIL empty_pop: got %h exp 00000005", bus.data);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_ovf_clear();
    drive(STA, 32'h0000_0003, 1'b1);
    tick();
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0000_0005) begin
      errors++; $display("FAIL ovf_keep: got %h exp 00000005", bus.data);
    end
    drive(STA, 32'h0000_0004, 1'b1);
    tick();
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0000_0001) begin
      errors++; $display("FAIL ovf_clear: got %h exp 00000001", bus.data);
    end
  endtask

  task automatic test_back_to_back();
    bus.tx_ready = 1'b0;
    drive(TXA, 32'hAAAA_0001, 1'b1);
    tick();
    bus.tx_ready = 1'b1;
    drive(TXA, 32'hBBBB_0002, 1'b1);
    checks++;
    if (bus.tx_data !== 32'hAAAA_0001) begin
      errors++; $display("FAIL b2b_head_a: got %h exp aaaa0001", bus.tx_data);
    end
    tick();
    bus.tx_ready = 1'b0;
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0000_0010 || bus.tx_data !== 32'hBBBB_0002) begin
      errors++; $display("FAIL b2b_pushpop_1: got st=%h d=%h exp st=00000010 d=bbbb0002", bus.data, bus.tx_data);
    end
    bus.tx_ready = 1'b1;
    drive(TXA, 32'hCCCC_0003, 1'b1);
    tick();
    bus.tx_ready = 1'b0;
    drive(STA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0000_0010 || bus.tx_data !== 32'hCCCC_0003) begin
      errors++; $display("FAIL b2b_pushpop_2: got st=%h d=%h exp st=00000010 d=cccc0003", bus.data, bus.tx_data);
    end
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    #1;
    checks++;
    if (bus.data !== 32'h0000_0001) begin
      errors++; $display("FAIL b2b_drained: got %h exp 00000001", bus.data);
    end
  endtask

  task automatic test_reset_mid();
    bus.tx_ready = 1'b0;
    for (int i = 21; i <= 24; i++) begin
      drive(TXA, 32'(i), 1'b1);
      tick();
    end
    bus.tx_ready = 1'b1;
    drive(STA, 32'h0, 1'b0);
    tick();
    checks++;
    if (bus.tx_data !== 32'd22 || bus.data !== 32'h0000_0030) begin
      errors++; $display("FAIL mid_three: got d=%h st=%h exp d=00000016 st=00000030", bus.tx_data, bus.data);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 32'h0 || bus.data !== 32'h0000_0001) begin
      errors++; $display("FAIL mid_reset: got v=%b d=%h st=%h exp v=0 d=00000000 st=00000001",
                         bus.tx_valid, bus.tx_data, bus.data);
    end
    drive(CYA, 32'h0, 1'b0);
    checks++;
    if (bus.data !== 32'h0) begin
      errors++; $display("FAIL mid_reset_cycles: got %h exp 00000000", bus.data);
    end
    rst = 1'b0;
    bus.tx_ready = 1'b0;
    drive(STA, 32'h0, 1'b0);
    tick();
    checks++;
    if (bus.data !== 32'h0000_0001 || bus.tx_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset: got st=%h v=%b exp st=00000001 v=0", bus.data, bus.tx_valid);
    end
  endtask

  initial begin
    bus.m_address = '0;
    bus.m_data    = '0;
    bus.memw_m    = 1'b0;
    bus.tx_ready  = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_cycles();
    test_ram();
    test_fifo_fill();
    test_push_pop_full();
    test_ovf_clear();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
